// File: rtl/rom_bcd_reader.sv
`timescale 1ns/1ps
// Reads one ROM word, converts it to packed BCD by shift-add-3, offers it on valid/ready.
// Latency: result valid 15 clocks after the start edge (defaults); ovf saturates to all-9s.
// Backpressure: result held stable in HOLD until out_ready; ROM_BCD_AUTO_SCAN_EN enables wrap-around scan.
module rom_bcd_reader #(
    parameter int N      = 3,
    parameter int O      = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N-1:0]        addr_req,
    output logic [N-1:0]        rom_addr,
    input  logic [O-1:0]        rom_data,
    output logic                busy,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(O + 1);

    function automatic longint pow10(input int d);
        longint p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    localparam logic [63:0]   LIMIT = 64'(pow10(DIGITS) - 1);
    localparam logic [BW-1:0] SAT   = {DIGITS{4'h9}};
    localparam logic [CW-1:0] LAST  = CW'(O - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_CONV,
        S_HOLD
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_rom_addr;
    logic [O-1:0]     r_shift;
    logic [BW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic [BW-1:0]    r_bcd;
    logic             r_ovf;
    logic             r_out_valid;
    logic             r_busy;

    logic [BW-1:0]    w_adj;
    logic [BW+O-1:0]  w_cat;
    logic [BW-1:0]    w_acc_next;
    logic [O-1:0]     w_shift_next;
    logic             w_over;

    // Add-3 correction on every nibble >= 5, then shift the combined {acc, shift} left.
    always_comb begin
        w_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ? (r_acc[4*i +: 4] + 4'd3)
                                                        : r_acc[4*i +: 4];
        end
        w_cat        = {w_adj, r_shift} << 1;
        w_acc_next   = w_cat[BW+O-1:O];
        w_shift_next = w_cat[O-1:0];
    end

    assign w_over = (64'(rom_data) > LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rom_addr  <= '0;
            r_shift     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_bcd       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rom_addr <= addr_req;
                        r_busy     <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_shift <= rom_data;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_ovf   <= w_over;
                    r_state <= S_CONV;
                end
                S_CONV: begin
                    r_acc   <= w_acc_next;
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt + CW'(1);
                    // Final iteration publishes directly so valid rises on the O-th conversion edge.
                    if (r_cnt == LAST) begin
                        r_bcd       <= r_ovf ? SAT : w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
`ifdef ROM_BCD_AUTO_SCAN_EN
                        r_rom_addr  <= r_rom_addr + N'(1);
                        r_state     <= S_FETCH;
`else
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr  = r_rom_addr;
    assign busy      = r_busy;
    assign bcd       = r_bcd;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

endmodule
